// File: rtl/arith_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : arith_scheduler_if
// Description : Requester, arithmetic-unit and response bundle for the
//               two-requester arithmetic scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface arith_scheduler_if #(
    parameter int WIDTH     = 16,
    parameter int FUN_WIDTH = 2
);
    // Requester 0
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic [FUN_WIDTH-1:0] req0_fun;

    // Requester 1
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic [FUN_WIDTH-1:0] req1_fun;

    // Arithmetic unit
    logic [WIDTH-1:0]     arith_a;
    logic [WIDTH-1:0]     arith_b;
    logic [FUN_WIDTH-1:0] arith_fun;
    logic                 arith_enable;
    logic [WIDTH-1:0]     arith_result;
    logic                 arith_carry;

    // Response
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 resp_id;
    logic [WIDTH-1:0]     resp_result;
    logic                 resp_carry;
    logic                 resp_err;

    logic                 busy;

    // Scheduler side
    modport master (
        input  req0_valid, req0_a, req0_b, req0_fun,
        input  req1_valid, req1_a, req1_b, req1_fun,
        input  arith_result, arith_carry, resp_ready,
        output req0_ready, req1_ready,
        output arith_a, arith_b, arith_fun, arith_enable,
        output resp_valid, resp_id, resp_result, resp_carry, resp_err,
        output busy
    );

    // Requesters, arithmetic unit and response consumer side
    modport slave (
        output req0_valid, req0_a, req0_b, req0_fun,
        output req1_valid, req1_a, req1_b, req1_fun,
        output arith_result, arith_carry, resp_ready,
        input  req0_ready, req1_ready,
        input  arith_a, arith_b, arith_fun, arith_enable,
        input  resp_valid, resp_id, resp_result, resp_carry, resp_err,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/arith_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : arith_scheduler
// Description : Round-robin scheduler sharing one arithmetic unit between two
//               requesters, with divide-by-zero short-circuit and held response.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_scheduler #(
    parameter int WIDTH     = 16,
    parameter int FUN_WIDTH = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_sched,
    arith_scheduler_if.master  bus
);

    localparam logic [FUN_WIDTH-1:0] c_fun_div = FUN_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_last_id;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [FUN_WIDTH-1:0] r_fun;
    logic                 r_id;
    logic [WIDTH-1:0]     r_result;
    logic                 r_carry;
    logic                 r_err;

    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_grant;
    logic [WIDTH-1:0]     w_sel_a;
    logic [WIDTH-1:0]     w_sel_b;
    logic [FUN_WIDTH-1:0] w_sel_fun;
    logic                 w_div_zero;

    // ------------------------------------------------------------------------
    // Arbitration: on contention the requester not granted last time wins.
    // r_last_id resets to 1 so that req0 wins the first contended grant.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == ST_IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_grant0 = r_last_id;
                w_grant1 = ~r_last_id;
            end else begin
                w_grant0 = bus.req0_valid;
                w_grant1 = bus.req1_valid;
            end
        end
    end

    assign w_grant    = w_grant0 | w_grant1;
    assign w_sel_a    = w_grant1 ? bus.req1_a   : bus.req0_a;
    assign w_sel_b    = w_grant1 ? bus.req1_b   : bus.req0_b;
    assign w_sel_fun  = w_grant1 ? bus.req1_fun : bus.req0_fun;
    assign w_div_zero = (w_sel_fun == c_fun_div) && (w_sel_b == '0);

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign bus.req0_ready = w_grant0 & rst_sched;
    assign bus.req1_ready = w_grant1 & rst_sched;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_sched) begin
        if (!rst_sched) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        bus.arith_enable = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                bus.busy = 1'b0;
                if (w_grant) begin
                    w_state_nxt = w_div_zero ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.arith_enable = 1'b1;
                w_state_nxt      = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Grant bookkeeping and operand latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_sched) begin
        if (!rst_sched) begin
            r_last_id <= 1'b1;
            r_id      <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_fun     <= '0;
        end else if (w_grant) begin
            r_last_id <= w_grant1;
            r_id      <= w_grant1;
            r_a       <= w_sel_a;
            r_b       <= w_sel_b;
            r_fun     <= w_sel_fun;
        end
    end

    // ------------------------------------------------------------------------
    // Response payload: carry is sampled while the unit is enabled, the
    // registered result one cycle later. Divide-by-zero fills it at grant.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_sched) begin
        if (!rst_sched) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_grant && w_div_zero) begin
                r_result <= '1;
                r_carry  <= 1'b0;
                r_err    <= 1'b1;
            end
            if (r_state == ST_ISSUE) begin
                r_carry <= bus.arith_carry;
            end
            if (r_state == ST_CAPTURE) begin
                r_result <= bus.arith_result;
                r_err    <= 1'b0;
            end
        end
    end

    assign bus.arith_a     = r_a;
    assign bus.arith_b     = r_b;
    assign bus.arith_fun   = r_fun;
    assign bus.resp_id     = r_id;
    assign bus.resp_result = r_result;
    assign bus.resp_carry  = r_carry;
    assign bus.resp_err    = r_err;

endmodule
`default_nettype wire

// File: doc/arith_scheduler.md
ARITH_SCHEDULER -- requirements
Module: arith_scheduler

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width.
REQ-002 Parameter FUN_WIDTH, default 2: operation code width (00 add, 01 sub, 10 mul, 11 div).
REQ-003 clk  in  1: single clock; all state updates on its rising edge.
REQ-004 rst_sched  in  1: reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  in  1: requester N presents an operation.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  WIDTH: requester N operands.
REQ-007 req0_fun / req1_fun  in  FUN_WIDTH: requester N operation code.
REQ-008 req0_ready / req1_ready  out  1: requester N operation accepted this cycle.
REQ-009 arith_a, arith_b  out  WIDTH: operands driven to the arithmetic unit.
REQ-010 arith_fun  out  FUN_WIDTH: operation code driven to the arithmetic unit.
REQ-011 arith_enable  out  1: arithmetic unit enable.
REQ-012 arith_result  in  WIDTH: registered result from the arithmetic unit.
REQ-013 arith_carry  in  1: combinational carry from the arithmetic unit.
REQ-014 resp_valid  out  1: response available; resp_ready  in  1: consumer accepts.
REQ-015 resp_id  out  1: requester index of the response.
REQ-016 resp_result  out  WIDTH; resp_carry  out  1; resp_err  out  1: response payload.
REQ-017 busy  out  1: high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, CAPTURE, RESP.
REQ-019 IDLE: if any reqN_valid, the arbiter SHALL grant exactly one requester, assert its reqN_ready combinationally in that cycle, and latch its a, b, fun, and id.
REQ-020 Arbitration SHALL be round-robin: when both are valid, the requester not granted most recently wins; after reset, req0 has priority.
REQ-021 With a single valid requester, that requester SHALL be granted regardless of the pointer; the pointer SHALL update on every grant.
REQ-022 reqN_ready SHALL be 0 in all states other than IDLE.
REQ-023 A granted op with fun=11 and b=0 SHALL go IDLE->RESP directly with resp_err=1, resp_result all ones, resp_carry=0, and arith_enable never asserted.
REQ-024 Otherwise IDLE->ISSUE: for exactly one cycle, arith_enable=1 and arith_a/arith_b/arith_fun = latched values; arith_carry SHALL be captured at the end of ISSUE.
REQ-025 ISSUE->CAPTURE unconditionally; arith_result SHALL be captured into resp_result at the end of CAPTURE, with resp_err=0.
REQ-026 CAPTURE->RESP; resp_valid=1 and the payload SHALL be held stable until the cycle where resp_ready=1, then RESP->IDLE.
REQ-027 resp_ready while resp_valid=0 SHALL be ignored.
REQ-028 Latency: accept in cycle T -> resp_valid from cycle T+3; divide-by-zero -> resp_valid from T+1; peak throughput one op per 4 cycles.
REQ-029 arith_a, arith_b, and arith_fun SHALL hold the last latched values outside ISSUE; arith_enable SHALL be 0 outside ISSUE.
REQ-030 Requests arriving while busy SHALL NOT be accepted and SHALL be served only after return to IDLE.

Reset
REQ-031 While rst_sched=0, the block SHALL immediately force IDLE and drive every output to 0; the round-robin pointer SHALL favour req0.
REQ-032 Reset asserted mid-operation SHALL drop the in-flight operation with no response.

Verification
REQ-033 Req0 add a=0x0003, b=0x0004 -> req0_ready in cycle T; arith_enable=1 only in T+1; resp_valid at T+3 with result 0x0007, carry 0, id 0.
REQ-034 Req1 add 0xFFFF+0x0001 -> resp_result 0x0000, resp_carry 1, id 1.
REQ-035 Both valid continuously after reset -> grants alternate 0,1,0,1 and responses carry matching ids.
REQ-036 Req0 div a=0x0010, b=0x0000 -> resp_valid at T+1, resp_err 1, resp_result 0xFFFF, arith_enable stays 0.
REQ-037 Hold resp_ready=0 for 5 cycles -> resp_valid and payload stay stable, no new grant; resp_ready=1 -> IDLE next cycle.
REQ-038 Assert rst_sched=0 during CAPTURE -> all outputs 0 asynchronously, no response after release, next grant goes to req0.
